// File: rtl/weight_medium_pkg.sv
// Shared types and sizing helpers for the weight-medium responder and its BRAM.
package weight_medium_pkg;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   function automatic int beats_f(input int w_size, input int beat_width);
      return w_size / beat_width;
   endfunction

   function automatic int bram_aw_f(input int length, input int beats);
      return (length * beats > 1) ? $clog2(length * beats) : 1;
   endfunction

endpackage

// File: rtl/weight_medium_if.sv
// CPU-side weight-medium bus: request/data from the control unit, completion back.
interface weight_medium_if #(
   parameter int ADDR_W = 8,
   parameter int W_SIZE = 1024
);
   logic [ADDR_W-1:0] addr_in;
   logic              read_enable_in;
   logic              write_enable_in;
   logic [W_SIZE-1:0] data_in;
   logic [W_SIZE-1:0] data_out;
   logic              finished_out;
   logic              busy_out;
   logic              parity_error_out;

   modport master (
      output addr_in, read_enable_in, write_enable_in, data_in,
      input  data_out, finished_out, busy_out, parity_error_out
   );

   modport slave (
      input  addr_in, read_enable_in, write_enable_in, data_in,
      output data_out, finished_out, busy_out, parity_error_out
   );
endinterface

// File: rtl/weight_bram.sv
// Single-port block RAM with a READ_LATENCY-deep registered read path; storage is never reset.
module weight_bram #(
   parameter int DEPTH        = 2048,
   parameter int WIDTH        = 128,
   parameter int AW           = 11,
   parameter int READ_LATENCY = 2
) (
   input  logic             clk_in,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] rd_pipe [READ_LATENCY];

   always_ff @(posedge clk_in) begin
      if (en && we) mem[addr] <= wdata;
      if (en && !we) rd_pipe[0] <= mem[addr];
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   assign rdata = rd_pipe[READ_LATENCY-1];

endmodule

// File: rtl/weight_medium.sv
// Weight-medium responder: bursts each wide word as BEATS narrow BRAM beats.
// Optional per-beat even parity enabled by defining WEIGHT_MEDIUM_PARITY_EN.
module weight_medium
   import weight_medium_pkg::*;
#(
   parameter int WEIGHT_LENGTH = 256,
   parameter int W_SIZE        = 1024,
   parameter int BEAT_WIDTH    = 128,
   parameter int READ_LATENCY  = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   weight_medium_if.slave bus
);

   localparam int BEATS = beats_f(W_SIZE, BEAT_WIDTH);
   localparam int BAW   = bram_aw_f(WEIGHT_LENGTH, BEATS);
   localparam int AW    = (WEIGHT_LENGTH > 1) ? $clog2(WEIGHT_LENGTH) : 1;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef WEIGHT_MEDIUM_PARITY_EN
   localparam int MW    = BEAT_WIDTH + 1;
`else
   localparam int MW    = BEAT_WIDTH;
`endif
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, ret_cnt_q;
   logic                    issue_done_q, rd_op_q, oor_q;
   logic [READ_LATENCY-1:0] vld_q;
   logic                    finished_q, busy_q;
   logic [W_SIZE-1:0]       data_out_q, staging_q, wdata_q;
   logic [AW-1:0]           addr_q;

   logic                    accept, oor_d, issue, rd_issue, vld_out;
   logic                    bram_en, bram_we;
   logic [BAW-1:0]          bram_addr;
   logic [BEAT_WIDTH-1:0]   wbeat;
   logic [MW-1:0]           bram_wdata, bram_rdata;

   assign accept   = (state_q == IDLE) && (bus.write_enable_in || bus.read_enable_in);
   assign oor_d    = (32'(bus.addr_in) >= 32'(WEIGHT_LENGTH));
   assign rd_issue = (state_q == READ) && !issue_done_q;
   assign issue    = (state_q == WRITE) || rd_issue;
   assign vld_out  = vld_q[READ_LATENCY-1];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.write_enable_in) state_d = WRITE;
                else if (bus.read_enable_in) state_d = READ;
         WRITE: if (cnt_q == LAST) state_d = DONE;
         READ:  if (vld_out && ret_cnt_q == LAST) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Out-of-range words never touch the array, so reads see zeros and writes vanish.
   assign bram_en   = issue && !oor_q;
   assign bram_we   = (state_q == WRITE);
   assign bram_addr = BAW'(addr_q) * BAW'(BEATS) + BAW'(cnt_q);
   assign wbeat     = wdata_q[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH];
`ifdef WEIGHT_MEDIUM_PARITY_EN
   assign bram_wdata = {^wbeat, wbeat};
`else
   assign bram_wdata = wbeat;
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         ret_cnt_q    <= '0;
         issue_done_q <= 1'b0;
         rd_op_q      <= 1'b0;
         oor_q        <= 1'b0;
         vld_q        <= '0;
         finished_q   <= 1'b0;
         busy_q       <= 1'b0;
         data_out_q   <= '0;
      end else begin
         state_q    <= state_d;
         finished_q <= (state_q == DONE);
         busy_q     <= (state_d != IDLE);
         vld_q[0]   <= rd_issue;
         for (int i = 1; i < READ_LATENCY; i++) vld_q[i] <= vld_q[i-1];
         if (accept) begin
            cnt_q        <= '0;
            ret_cnt_q    <= '0;
            issue_done_q <= 1'b0;
            rd_op_q      <= !bus.write_enable_in;
            oor_q        <= oor_d;
         end else begin
            if (issue && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
            if (rd_issue && cnt_q == LAST) issue_done_q <= 1'b1;
            if (vld_out) ret_cnt_q <= ret_cnt_q + 1'b1;
         end
         // Whole word lands at once so data_out is never partially assembled.
         if (state_q == DONE && rd_op_q) data_out_q <= oor_q ? '0 : staging_q;
      end
   end

   always_ff @(posedge clk_in) begin
      if (accept) begin
         addr_q <= bus.addr_in;
         if (bus.write_enable_in) wdata_q <= bus.data_in;
      end
      if (vld_out) staging_q[int'(ret_cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] <= bram_rdata[BEAT_WIDTH-1:0];
   end

`ifdef WEIGHT_MEDIUM_PARITY_EN
   logic perr_acc_q, perr_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         perr_acc_q <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         if (accept) perr_acc_q <= 1'b0;
         else if (vld_out && !oor_q && ^bram_rdata) perr_acc_q <= 1'b1;
         if (state_q == DONE && rd_op_q) perr_q <= perr_q | perr_acc_q;
      end
   end

   assign bus.parity_error_out = perr_q;
`else
   assign bus.parity_error_out = 1'b0;
`endif

   assign bus.data_out     = data_out_q;
   assign bus.finished_out = finished_q;
   assign bus.busy_out     = busy_q;

   weight_bram #(
      .DEPTH        (WEIGHT_LENGTH * BEATS),
      .WIDTH        (MW),
      .AW           (BAW),
      .READ_LATENCY (READ_LATENCY)
   ) u_bram (
      .clk_in (clk_in),
      .en     (bram_en),
      .we     (bram_we),
      .addr   (bram_addr),
      .wdata  (bram_wdata),
      .rdata  (bram_rdata)
   );

endmodule

// File: tb/tb_weight_medium.sv
// Directed bench for weight_medium: table of transfers plus reset, overlap and parity sequences.
module tb_weight_medium;

   localparam int W = 1024;

   typedef struct {
      logic         is_wr;
      logic         is_rd;
      logic [7:0]   addr;
      logic [W-1:0] wdata;
      int           exp_lat;
      logic [W-1:0] exp_dout;
   } vec_t;

   localparam logic [W-1:0] PAT_A = {64{16'hA5A5}};
   localparam logic [W-1:0] PAT_C = {32{32'h1234_5678}};
   localparam logic [W-1:0] PAT_X = {16{64'hDEAD_BEEF_0BAD_F00D}};
   localparam logic [W-1:0] PAT_Y = {128{8'h3C}};
   localparam logic [W-1:0] PAT_Z = {32{32'h0F0F_1E2D}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   logic [W-1:0] word7;
   vec_t         vecs[7];
   int           fin_k;
   logic [W-1:0] dout_fin;
   logic         stable, busy1;
   int           npulse;

   weight_medium_if #(.ADDR_W(8), .W_SIZE(W)) bus ();

   weight_medium dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk_i(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         for (int b = 0; b < 8; b++) begin
            if (act[b*128 +: 128] !== exp[b*128 +: 128]) begin
               $display("FAIL %s: beat %0d got %h expected %h", name, b, act[b*128 +: 128], exp[b*128 +: 128]);
               break;
            end
         end
      end
   endtask

   // Called #1 after an active edge; the next edge is request edge 0.
   task automatic run_xfer(input logic wr, input logic rd, input logic [7:0] a,
                           input logic [W-1:0] d, input int inj_k,
                           output int fk, output logic [W-1:0] dout,
                           output logic stab, output logic b1);
      logic [W-1:0] prev;
      bus.addr_in = a;
      bus.write_enable_in = wr;
      bus.read_enable_in = rd;
      bus.data_in = d;
      prev = bus.data_out;
      @(posedge clk); #1;
      bus.write_enable_in = 1'b0;
      bus.read_enable_in = 1'b0;
      fk = -1;
      stab = 1'b1;
      b1 = 1'b0;
      dout = '0;
      for (int k = 1; k <= 40 && fk < 0; k++) begin
         @(posedge clk); #1;
         if (k == 1) b1 = bus.busy_out;
         if (bus.read_enable_in) bus.read_enable_in = 1'b0;
         if (bus.finished_out) begin
            fk = k;
            dout = bus.data_out;
         end else begin
            if (bus.data_out !== prev) stab = 1'b0;
            if (k == inj_k) begin
               bus.read_enable_in = 1'b1;
               bus.addr_in = 8'd5;
            end
         end
      end
   endtask

   task automatic idle_chk(input string name);
      @(posedge clk); #1;
      chk_i({name, "_fin_drop"}, int'(bus.finished_out), 0);
      chk_i({name, "_busy_drop"}, int'(bus.busy_out), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int b = 0; b < 8; b++) word7[b*128 +: 128] = 128'(b);
      vecs[0] = '{1'b1, 1'b0, 8'd3,   PAT_A, 9,  word7};
      vecs[1] = '{1'b0, 1'b1, 8'd3,   '0,    11, PAT_A};
      vecs[2] = '{1'b1, 1'b1, 8'd5,   PAT_C, 9,  PAT_A};
      vecs[3] = '{1'b0, 1'b1, 8'd5,   '0,    11, PAT_C};
      vecs[4] = '{1'b1, 1'b0, 8'd200, PAT_X, 9,  PAT_C};
      vecs[5] = '{1'b0, 1'b1, 8'd200, '0,    11, PAT_X};
      vecs[6] = '{1'b0, 1'b1, 8'd7,   '0,    11, word7};

      bus.addr_in = '0;
      bus.read_enable_in = 1'b0;
      bus.write_enable_in = 1'b0;
      bus.data_in = '0;
      #22;
      chk_w("rst_data_out", bus.data_out, '0);
      chk_i("rst_finished", int'(bus.finished_out), 0);
      chk_i("rst_busy", int'(bus.busy_out), 0);
      chk_i("rst_parity", int'(bus.parity_error_out), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Preload addr 7 with beat b = b, then reset so the read starts from a fresh block.
      run_xfer(1'b1, 1'b0, 8'd7, word7, 0, fin_k, dout_fin, stable, busy1);
      chk_i("preload_lat", fin_k, 9);
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_xfer(1'b0, 1'b1, 8'd7, '0, 0, fin_k, dout_fin, stable, busy1);
      chk_i("rd7_lat", fin_k, 11);
      chk_i("rd7_busy", int'(busy1), 1);
      chk_i("rd7_dout_held_zero", int'(stable), 1);
      chk_w("rd7_dout", dout_fin, word7);
      idle_chk("rd7");

      for (int i = 0; i < 7; i++) begin
         run_xfer(vecs[i].is_wr, vecs[i].is_rd, vecs[i].addr, vecs[i].wdata, 0,
                  fin_k, dout_fin, stable, busy1);
         chk_i($sformatf("vec%0d_lat", i), fin_k, vecs[i].exp_lat);
         chk_i($sformatf("vec%0d_busy", i), int'(busy1), 1);
         chk_i($sformatf("vec%0d_stable", i), int'(stable), 1);
         chk_w($sformatf("vec%0d_dout", i), dout_fin, vecs[i].exp_dout);
         idle_chk($sformatf("vec%0d", i));
      end

      // Read with a stray read pulse mid-burst, then a write issued on the finished cycle.
      run_xfer(1'b0, 1'b1, 8'd3, '0, 3, fin_k, dout_fin, stable, busy1);
      chk_i("ovl_lat", fin_k, 11);
      chk_w("ovl_dout", dout_fin, PAT_A);
      run_xfer(1'b1, 1'b0, 8'd9, PAT_Z, 0, fin_k, dout_fin, stable, busy1);
      chk_i("b2b_lat", fin_k, 9);
      chk_i("b2b_busy", int'(busy1), 1);
      chk_w("b2b_dout", dout_fin, PAT_A);
      idle_chk("b2b");
      run_xfer(1'b0, 1'b1, 8'd9, '0, 0, fin_k, dout_fin, stable, busy1);
      chk_w("b2b_rd9", dout_fin, PAT_Z);

      // Reset during beat 4 of a write.
      bus.addr_in = 8'd11;
      bus.data_in = PAT_Y;
      bus.write_enable_in = 1'b1;
      @(posedge clk); #1;
      bus.write_enable_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk_i("midrst_busy_before", int'(bus.busy_out), 1);
      rst_n = 1'b0;
      #1;
      chk_w("midrst_dout", bus.data_out, '0);
      chk_i("midrst_busy", int'(bus.busy_out), 0);
      chk_i("midrst_fin", int'(bus.finished_out), 0);
      npulse = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (bus.finished_out) npulse++;
      end
      chk_i("midrst_no_pulse", npulse, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_xfer(1'b0, 1'b1, 8'd7, '0, 0, fin_k, dout_fin, stable, busy1);
      chk_i("postrst_lat", fin_k, 11);
      chk_w("postrst_dout", dout_fin, word7);

`ifdef WEIGHT_MEDIUM_PARITY_EN
      dut.u_bram.mem[3*8+2][5] = ~dut.u_bram.mem[3*8+2][5];
      chk_i("par_before", int'(bus.parity_error_out), 0);
      run_xfer(1'b0, 1'b1, 8'd3, '0, 0, fin_k, dout_fin, stable, busy1);
      chk_i("par_lat", fin_k, 11);
      chk_i("par_set", int'(bus.parity_error_out), 1);
      run_xfer(1'b0, 1'b1, 8'd7, '0, 0, fin_k, dout_fin, stable, busy1);
      chk_i("par_sticky", int'(bus.parity_error_out), 1);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk_i("par_cleared", int'(bus.parity_error_out), 0);
      @(negedge clk) rst_n = 1'b1;
`else
      chk_i("par_off", int'(bus.parity_error_out), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
